// File: rtl/regfile_2r1w.sv
// ---------------------------------------------------------------------------
// regfile_2r1w
// Parametrised two-read / one-write register file for the ALU operand path.
// After every reset an init sequencer walks the whole array writing zero,
// one entry per clock, while busy_o is held high and both read ports are
// forced to zero. Once the sequencer finishes, the array behaves as a normal
// register file with combinational reads, an optional write-through bypass
// and an optional hard-wired zero register at entry 0.
//
// Ports
//   clk_i       in   1       single clock, all state updates on rising edge
//   rst_i       in   1       synchronous active-high reset, restarts init
//   rd_addr1_i  in   ADDR_W  read port 1 address
//   rd_addr2_i  in   ADDR_W  read port 2 address
//   rd_data1_o  out  DATA_W  read port 1 data, combinational
//   rd_data2_o  out  DATA_W  read port 2 data, combinational
//   we_i        in   1       write enable (ignored while initialising)
//   wr_addr_i   in   ADDR_W  write address
//   wr_data_i   in   DATA_W  write data
//   busy_o      out  1       high while the init sequencer clears the array
// ---------------------------------------------------------------------------
module regfile_2r1w #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] rd_addr1_i,
    input  logic [ADDR_W-1:0] rd_addr2_i,
    output logic [DATA_W-1:0] rd_data1_o,
    output logic [DATA_W-1:0] rd_data2_o,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              busy_o
);

    localparam int unsigned       DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_accept;

    // Next-state logic for the init sequencer. In INIT the clear counter
    // advances every cycle; clearing the last entry is what hands control to
    // RUN, and the counter wraps back to zero on that same edge.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        busy_d    = busy_q;
        case (state_q)
            ST_INIT: begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == LAST_IDX) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b0;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Sequencer state register. Reset can land in either state and always
    // restarts the clear from entry 0 with busy raised.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
        end
    end

    // A user write only lands in RUN, and never on the zero register when
    // that feature is enabled.
    always_comb begin
        wr_accept = we_i && (state_q == ST_RUN);
        if ((ZERO_REG != 0) && (wr_addr_i == '0)) begin
            wr_accept = 1'b0;
        end
    end

    // Storage array. It has no reset of its own: its content is only
    // observable after the sequencer has overwritten every entry with zero.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == ST_INIT) begin
                mem_q[clr_cnt_q] <= '0;
            end else if (wr_accept) begin
                mem_q[wr_addr_i] <= wr_data_i;
            end
        end
    end

    // Read port 1. Priority: forced zero while initialising, then the zero
    // register, then same-cycle forwarding of the write data, then the array.
    always_comb begin
        rd_data1_o = mem_q[rd_addr1_i];
        if (busy_q) begin
            rd_data1_o = '0;
        end else if ((ZERO_REG != 0) && (rd_addr1_i == '0)) begin
            rd_data1_o = '0;
        end else if ((BYPASS != 0) && we_i && (wr_addr_i == rd_addr1_i)) begin
            rd_data1_o = wr_data_i;
        end
    end

    // Read port 2, same priority order as port 1.
    always_comb begin
        rd_data2_o = mem_q[rd_addr2_i];
        if (busy_q) begin
            rd_data2_o = '0;
        end else if ((ZERO_REG != 0) && (rd_addr2_i == '0)) begin
            rd_data2_o = '0;
        end else if ((BYPASS != 0) && we_i && (wr_addr_i == rd_addr2_i)) begin
            rd_data2_o = wr_data_i;
        end
    end

    assign busy_o = busy_q;

endmodule
